spi_bus_arbiter: RTL and testbench

//  Shares one Spi master (WIDTH-bit shift, trig/done handshake) between CLIENTS requesters,
//  e.g. DAC, preamp and ADC on a common SCK/MOSI bus. Round-robin arbitration, per-client

---
 rtl/spi_bus_arbiter_pkg.sv | 7 +
 rtl/spi_rr_picker.sv | 26 ++
 rtl/spi_bus_arbiter.sv | 96 +++++++++
 tb/tb_spi_bus_arbiter.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/spi_bus_arbiter_pkg.sv
// spi_bus_arbiter_pkg: FSM state encoding and pointer-width helper shared by the SPI arbiter files
package spi_bus_arbiter_pkg;
  typedef enum logic [1:0] {S_IDLE, S_START, S_BUSY, S_GAP} state_t;
  function automatic int ptr_w(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction
endpackage

// File: rtl/spi_rr_picker.sv
// spi_rr_picker: combinational round-robin pick, first request at or after ptr with wrap
module spi_rr_picker #(
  parameter int N  = 3,
  parameter int PW = 2
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  win,
  output logic [PW-1:0] idx,
  output logic          any
);
  logic found;
  always_comb begin
    win = '0;
    idx = '0;
    found = 1'b0;
    for (int k = 0; k < N; k++) begin
      if (!found && req[(int'(ptr) + k) % N]) begin
        found = 1'b1;
        idx = PW'((int'(ptr) + k) % N);
        win[(int'(ptr) + k) % N] = 1'b1;
      end
    end
  end
  assign any = |req;
endmodule

// File: rtl/spi_bus_arbiter.sv
// spi_bus_arbiter: round-robin sharing of one SPI master between CLIENTS requesters with CS routing
// SPI_ARB_TIMEOUT_EN enables a BUSY watchdog that aborts a frame after TIMEOUT cycles with err.
module spi_bus_arbiter
  import spi_bus_arbiter_pkg::*;
#(
  parameter int CLIENTS = 3,
  parameter int WIDTH   = 32,
  parameter int GAP     = 4,
  parameter int TIMEOUT = 256
) (
  input  logic                       CLK50MHZ,
  input  logic                       RST,
  input  logic [CLIENTS-1:0]         req,
  input  logic [CLIENTS*WIDTH-1:0]   wdata,
  output logic [CLIENTS-1:0]         gnt,
  output logic [CLIENTS-1:0]         done,
  output logic                       err,
  output logic [WIDTH-1:0]           rdata,
  output logic [CLIENTS-1:0]         cs_n,
  output logic                       m_trig,
  output logic [WIDTH-1:0]           m_data_in,
  input  logic                       m_done,
  input  logic [WIDTH-1:0]           m_data_out,
  input  logic                       m_cs
);
  localparam int PW = ptr_w(CLIENTS);
  localparam int GW = ptr_w(GAP + 1);
  state_t state;
  logic [PW-1:0] ptr, sel, idx;
  logic sel_valid, any, expire;
  logic [CLIENTS-1:0] win;
  logic [GW-1:0] gap_cnt;
  spi_rr_picker #(.N(CLIENTS), .PW(PW)) picker (
    .req(req), .ptr(ptr), .win(win), .idx(idx), .any(any)
  );
  for (genvar g = 0; g < CLIENTS; g++) begin : g_cs
    assign cs_n[g] = (sel_valid && sel == PW'(g)) ? m_cs : 1'b1;
  end
`ifdef SPI_ARB_TIMEOUT_EN
  localparam int TW = ptr_w(TIMEOUT + 1);
  logic [TW-1:0] tcnt;
  always_ff @(posedge CLK50MHZ) begin
    if (RST || state != S_BUSY) tcnt <= '0;
    else tcnt <= tcnt + 1'b1;
  end
  assign expire = (state == S_BUSY) && (tcnt == TW'(TIMEOUT - 1));
`else
  assign expire = 1'b0;
`endif
  always_ff @(posedge CLK50MHZ) begin
    if (RST) begin
      state <= S_IDLE;
      gnt <= '0;
      done <= '0;
      err <= 1'b0;
      m_trig <= 1'b0;
      m_data_in <= '0;
      rdata <= '0;
      ptr <= '0;
      sel <= '0;
      sel_valid <= 1'b0;
      gap_cnt <= '0;
    end else begin
      done <= '0;
      err <= 1'b0;
      m_trig <= 1'b0;
      case (state)
        S_IDLE: if (any) begin
          gnt <= win;
          sel <= idx;
          sel_valid <= 1'b1;
          m_data_in <= wdata[idx*WIDTH +: WIDTH];
          m_trig <= 1'b1;
          state <= S_START;
        end
        S_START: state <= S_BUSY;
        S_BUSY: if (m_done || expire) begin
          // a real m_done in the expiry cycle wins over the watchdog
          done <= CLIENTS'(1) << sel;
          err <= !m_done;
          if (m_done) rdata <= m_data_out;
          gnt <= '0;
          ptr <= (sel == PW'(CLIENTS - 1)) ? '0 : sel + 1'b1;
          gap_cnt <= '0;
          sel_valid <= (GAP != 0);
          state <= (GAP != 0) ? S_GAP : S_IDLE;
        end
        S_GAP: if (gap_cnt == GW'(GAP - 1)) begin
          sel_valid <= 1'b0;
          state <= S_IDLE;
        end else gap_cnt <= gap_cnt + 1'b1;
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_spi_bus_arbiter.sv
// tb_spi_bus_arbiter: randomized directed bench with a loopback SPI model and round-robin reference
module tb_spi_bus_arbiter;
  localparam int CLIENTS = 3;
  localparam int WIDTH = 32;
  localparam int GAP = 4;
  localparam int TIMEOUT = 16;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [2:0] req = '0;
  logic [95:0] wdata = '0;
  logic [2:0] gnt, done, cs_n;
  logic err, m_trig;
  logic [31:0] rdata, m_data_in;
  logic m_done = 1'b0;
  logic [31:0] m_data_out = '0;
  logic m_cs = 1'b1;
  spi_bus_arbiter #(.CLIENTS(CLIENTS), .WIDTH(WIDTH), .GAP(GAP), .TIMEOUT(TIMEOUT)) dut (
    .CLK50MHZ(clk), .RST(rst), .req(req), .wdata(wdata), .gnt(gnt), .done(done),
    .err(err), .rdata(rdata), .cs_n(cs_n), .m_trig(m_trig), .m_data_in(m_data_in),
    .m_done(m_done), .m_data_out(m_data_out), .m_cs(m_cs)
  );
  always #10 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;
  // loopback SPI master model: frame lasts a random number of cycles, MISO echoes MOSI
  logic busy_m = 1'b0, stuck = 1'b0, abort = 1'b0, spur = 1'b0;
  logic [31:0] shreg = '0;
  int lat = 0;
  always @(posedge clk) begin
    m_done <= spur;
    if (rst || abort) begin
      busy_m <= 1'b0;
      m_cs <= 1'b1;
    end else if (busy_m) begin
      if (!stuck) begin
        if (lat == 0) begin
          m_done <= 1'b1;
          m_data_out <= shreg;
          m_cs <= 1'b1;
          busy_m <= 1'b0;
        end else lat <= lat - 1;
      end
    end else if (m_trig) begin
      busy_m <= 1'b1;
      m_cs <= 1'b0;
      shreg <= m_data_in;
      lat <= int'($urandom_range(12, 3));
    end
  end
  int vectors = 0, fails = 0;
  int rptr = 0, last_done = -100;
  task automatic chk(input string tag, input logic [95:0] obs, input logic [95:0] exp);
    vectors++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  function automatic int pick(input logic [2:0] r, input int p);
    for (int k = 0; k < 3; k++) if (r[(p + k) % 3]) return (p + k) % 3;
    return -1;
  endfunction
  function automatic logic [31:0] slice(input int c);
    return wdata[c*32 +: 32];
  endfunction
  task automatic randomize_wdata();
    for (int i = 0; i < 3; i++) wdata[i*32 +: 32] = $urandom;
  endtask
  task automatic serve(input int c, input bit drop_mid);
    int n, trig_cyc, trigs;
    bit cs_bad;
    logic [31:0] exp_d;
    n = 0;
    while (gnt === 3'b000 && n < 40) begin @(negedge clk); n++; end
    chk("grant", gnt, 3'b001 << c);
    exp_d = slice(c);
    chk("m_data_in", m_data_in, exp_d);
    trigs = 0; cs_bad = 0; trig_cyc = -1; n = 0;
    while (done === 3'b000 && n < 80) begin
      if (m_trig) begin trigs++; if (trig_cyc < 0) trig_cyc = cyc; end
      for (int i = 0; i < 3; i++)
        if ((i != c && cs_n[i] !== 1'b1) || (i == c && cs_n[i] !== m_cs)) cs_bad = 1;
      if (drop_mid && trig_cyc >= 0) req[c] = 1'b0;
      @(negedge clk); n++;
    end
    chk("trig_count", trigs, 1);
    if (last_done >= 0) chk("gap_spacing", (trig_cyc - last_done) >= GAP + 1, 1);
    chk("cs_route", cs_bad, 0);
    chk("done", done, 3'b001 << c);
    chk("err", err, 0);
    chk("rdata", rdata, exp_d);
    chk("gnt_clear", gnt, 0);
    last_done = cyc;
    rptr = (c + 1) % 3;
    @(negedge clk);
    chk("done_pulse", done, 0);
  endtask
  initial begin
    int n, c, t0;
    logic [31:0] saved;
    repeat (3) @(negedge clk);
    chk("rst_gnt", gnt, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    chk("rst_trig", m_trig, 0);
    chk("rst_mdin", m_data_in, 0);
    chk("rst_rdata", rdata, 0);
    chk("rst_cs", cs_n, 3'b111);
    rst = 1'b0;
    @(negedge clk);
    spur = 1'b1;
    @(negedge clk);
    spur = 1'b0;
    repeat (3) @(negedge clk);
    chk("spur_done", done, 0);
    chk("spur_gnt", gnt, 0);
    randomize_wdata();
    wdata[63:32] = 32'hA5A5_0001;
    req = 3'b010;
    @(negedge clk);
    chk("grant_latency", gnt, 3'b010);
    serve(1, 0);
    chk("loopback", rdata, 32'hA5A5_0001);
    req = 3'b000;
    req = 3'b111;
    for (int k = 0; k < 6; k++) begin
      randomize_wdata();
      serve(pick(req, rptr), 0);
    end
    req = 3'b000;
    repeat (8) @(negedge clk);
    chk("idle_no_gnt", gnt, 0);
    req = 3'b001;
    serve(0, 0);
    req = 3'b101;
    serve(2, 0);
    req[2] = 1'b0;
    serve(0, 0);
    req = 3'b000;
    randomize_wdata();
    req = 3'b001;
    serve(0, 1);
    repeat (15) @(negedge clk);
    chk("no_regrant", gnt, 0);
    for (int k = 0; k < 12; k++) begin
      req = 3'($urandom_range(7, 1));
      randomize_wdata();
      serve(pick(req, rptr), 0);
    end
    req = 3'b000;
    repeat (8) @(negedge clk);
    req = 3'b010;
    n = 0;
    while (!m_trig && n < 40) begin @(negedge clk); n++; end
    chk("rst_test_trig", m_trig, 1);
    repeat (11) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("abort_gnt", gnt, 0);
    chk("abort_cs", cs_n, 3'b111);
    chk("abort_trig", m_trig, 0);
    chk("abort_done", done, 0);
    rst = 1'b0;
    rptr = 0;
    last_done = -100;
    req = 3'b111;
    randomize_wdata();
    serve(0, 0);
    req = 3'b000;
    repeat (8) @(negedge clk);
`ifdef SPI_ARB_TIMEOUT_EN
    stuck = 1'b1;
    saved = rdata;
    req = 3'b001;
    randomize_wdata();
    n = 0;
    while (!m_trig && n < 40) begin @(negedge clk); n++; end
    t0 = cyc;
    n = 0;
    while (done === 3'b000 && n < 60) begin @(negedge clk); n++; end
    chk("to_latency", cyc - t0, TIMEOUT + 1);
    chk("to_done", done, 3'b001);
    chk("to_err", err, 1);
    chk("to_rdata", rdata, saved);
    req = 3'b000;
    rptr = 1;
    last_done = cyc;
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    stuck = 1'b0;
    chk("to_err_pulse", err, 0);
    req = 3'b100;
    serve(2, 0);
    req = 3'b000;
`endif
    repeat (4) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end
  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end
endmodule
